// File: rtl/bus_slave_mux_tmo_if.sv
// -----------------------------------------------------------------------------
// bus_slave_mux_tmo_if
//   Read-response bus between N slaves and the response multiplexer.
//
//   s_csn    per-slave chip select, active low (bit i = slave i)
//   s_rdata  packed slave read data, slave i at [i*DATA_W +: DATA_W]
//   s_rdyn   per-slave ready, active low
//   m_rdata  read data to master
//   m_rdyn   ready to master, active low
//   m_err    forced (timeout) completion flag
//
//   modport slave  : the multiplexer (consumes s_*, produces m_*)
//   modport master : the environment (drives s_*, observes m_*)
// -----------------------------------------------------------------------------
interface bus_slave_mux_tmo_if #(
    parameter int NUM_SLAVES = 8,
    parameter int DATA_W     = 32
);
    logic [NUM_SLAVES-1:0]        s_csn;
    logic [NUM_SLAVES*DATA_W-1:0] s_rdata;
    logic [NUM_SLAVES-1:0]        s_rdyn;
    logic [DATA_W-1:0]            m_rdata;
    logic                         m_rdyn;
    logic                         m_err;

    modport slave (
        input  s_csn, s_rdata, s_rdyn,
        output m_rdata, m_rdyn, m_err
    );

    modport master (
        output s_csn, s_rdata, s_rdyn,
        input  m_rdata, m_rdyn, m_err
    );
endinterface

// File: rtl/bus_slave_mux_tmo.sv
// -----------------------------------------------------------------------------
// bus_slave_mux_tmo
//   Read-response multiplexer for NUM_SLAVES bus slaves with a per-transaction
//   wait timeout. The lowest-indexed selected slave is served combinationally;
//   a slave that keeps rdyn high for TIMEOUT cycles is completed forcibly with
//   ERR_DATA and a one-cycle m_err pulse. Sticky status records timeouts and
//   multi-select decode faults.
//
//   Parameters: NUM_SLAVES (2..32), DATA_W, TIMEOUT (0 disables), ERR_DATA.
//
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   bus          slave side of bus_slave_mux_tmo_if (s_* in, m_* out)
//   clr_sts      one-cycle pulse clearing all sticky status
//   tmo_sticky   set by any forced completion
//   tmo_slave    slave index of the most recent forced completion
//   tmo_count    forced completion count, saturates at 255
//   msel_sticky  set when two or more chip selects are low together
// -----------------------------------------------------------------------------
module bus_slave_mux_tmo #(
    parameter int          NUM_SLAVES = 8,
    parameter int          DATA_W     = 32,
    parameter int          TIMEOUT    = 16,
    parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF,
    localparam int         IDX_W      = $clog2(NUM_SLAVES)
) (
    input  logic                      clk,
    input  logic                      rst,
    bus_slave_mux_tmo_if.slave        bus,
    input  logic                      clr_sts,
    output logic                      tmo_sticky,
    output logic [IDX_W-1:0]          tmo_slave,
    output logic [7:0]                tmo_count,
    output logic                      msel_sticky
);

    // A zero TIMEOUT still needs a legal (1-bit) counter; it is never compared.
    localparam int                 WCNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WCNT_W-1:0]  WCNT_MAX = WCNT_W'(TIMEOUT);
    localparam logic [DATA_W-1:0]  ERR_WORD = DATA_W'(ERR_DATA);
    localparam bit                 TMO_EN   = (TIMEOUT != 0);

    logic                  sel_vld;
    logic [IDX_W-1:0]      sel_idx;
    logic                  sel_rdyn;
    logic [DATA_W-1:0]     sel_data;
    logic [NUM_SLAVES-1:0] csn_low;
    logic                  multi_sel;
    logic                  tmo_hit;
    logic                  rdyn_out;

    logic [WCNT_W-1:0]     wcnt;
    logic [WCNT_W-1:0]     wcnt_nxt;
    logic [IDX_W-1:0]      prev_idx;
    logic                  prev_vld;

    // Priority select: scanning downwards lets the lowest index win.
    always_comb begin
        sel_vld  = 1'b0;
        sel_idx  = '0;
        sel_rdyn = 1'b1;
        sel_data = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (!bus.s_csn[i]) begin
                sel_vld  = 1'b1;
                sel_idx  = IDX_W'(i);
                sel_rdyn = bus.s_rdyn[i];
                sel_data = bus.s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // x & (x-1) clears the lowest set bit; anything left means >= 2 selects.
    assign csn_low   = ~bus.s_csn;
    assign multi_sel = |(csn_low & (csn_low - {{(NUM_SLAVES-1){1'b0}}, 1'b1}));

    // A slave that becomes ready in the boundary cycle wins over the timeout.
    assign tmo_hit = TMO_EN && sel_vld && sel_rdyn && (wcnt == WCNT_MAX);

    always_comb begin
        rdyn_out    = 1'b1;
        bus.m_rdata = '0;
        bus.m_err   = 1'b0;
        if (sel_vld) begin
            if (tmo_hit) begin
                rdyn_out    = 1'b0;
                bus.m_rdata = ERR_WORD;
                bus.m_err   = 1'b1;
            end else begin
                rdyn_out    = sel_rdyn;
                bus.m_rdata = sel_data;
            end
        end
        bus.m_rdyn = rdyn_out;
    end

    // The index-change restart only applies when the previous cycle was also
    // selected; a transaction starting from idle begins counting immediately,
    // so a stuck slave is forced exactly TIMEOUT cycles after selection.
    always_comb begin
        wcnt_nxt = wcnt + 1'b1;
        if (!sel_vld || !rdyn_out || (prev_vld && (sel_idx != prev_idx)))
            wcnt_nxt = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt     <= '0;
            prev_idx <= '0;
            prev_vld <= 1'b0;
        end else begin
            wcnt     <= wcnt_nxt;
            prev_vld <= sel_vld;
            if (sel_vld)
                prev_idx <= sel_idx;
        end
    end

    // Status: a set event in the same cycle as clr_sts takes precedence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_sticky  <= 1'b0;
            tmo_slave   <= '0;
            tmo_count   <= '0;
            msel_sticky <= 1'b0;
        end else begin
            if (tmo_hit) begin
                tmo_sticky <= 1'b1;
                tmo_slave  <= sel_idx;
                if (clr_sts)
                    tmo_count <= 8'd1;
                else if (tmo_count != 8'hFF)
                    tmo_count <= tmo_count + 8'd1;
            end else if (clr_sts) begin
                tmo_sticky <= 1'b0;
                tmo_slave  <= '0;
                tmo_count  <= '0;
            end

            if (multi_sel)
                msel_sticky <= 1'b1;
            else if (clr_sts)
                msel_sticky <= 1'b0;
        end
    end

endmodule
